ifid_pipe_stage: RTL and testbench

Parametrised successor of the IF/ID stage register: carries PC, instruction word and write-back flag from fetch to decode using a valid/ready handshake with a two-entry skid buffer for full throughput under back-pressure. Supports stall (hazard), flush (branch/jump redirect) and a saturating stall-cycle counter. It sits between the instruction-memory fetch logic and the decode/register-read stage and replaces the fixed 8-bit hazard-hold register.

---
 rtl/ifid_pkg.sv | 30 +++
 rtl/ifid_stall_counter.sv | 28 ++
 rtl/ifid_pipe_stage.sv | 174 +++++++++++++++++
 tb/tb_ifid_pipe_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// Shared types and defaults for the IF/ID pipeline stage.
package ifid_pkg;

  // Default widths; the top exposes these as overridable parameters.
  localparam int IFID_PC_W_DEF    = 8;
  localparam int IFID_INSTR_W_DEF = 32;
  localparam int IFID_STALL_W_DEF = 16;

  // Occupancy of the stage: nothing, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } ifid_state_e;

  // One fetch beat at default widths.
  typedef struct packed {
    logic [IFID_PC_W_DEF-1:0]    pc;
    logic [IFID_INSTR_W_DEF-1:0] instr;
    logic                        wb_ff;
  } ifid_payload_t;

  // Value held by the payload registers coming out of reset.
  localparam ifid_payload_t IFID_PAYLOAD_RST = '{
    pc:    {IFID_PC_W_DEF{1'b0}},
    instr: {IFID_INSTR_W_DEF{1'b0}},
    wb_ff: 1'b0
  };

endpackage

// File: rtl/ifid_stall_counter.sv
// Saturating count of cycles in which the stage held a beat it could not hand on.
module ifid_stall_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;
  logic             at_max_s;

  assign at_max_s = (count_r == {WIDTH{1'b1}});
  assign count    = count_r;

  // Count up on each stalled cycle, sticking at all-ones; only reset clears it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID stage register with valid/ready handshake, optional two-entry skid
// buffer, stall (hazard), flush and a saturating stall-cycle counter.
module ifid_pipe_stage
  import ifid_pkg::*;
#(
  parameter int INSTMEM_LOG2_DEEP = IFID_PC_W_DEF,
  parameter int INSTR_WIDTH       = IFID_INSTR_W_DEF,
  parameter bit SKID_EN           = 1'b1,
  parameter int STALL_CNT_WIDTH   = IFID_STALL_W_DEF
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [INSTMEM_LOG2_DEEP-1:0] PC_in,
  input  logic [INSTR_WIDTH-1:0]       instr_in,
  input  logic                         wb_ff_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         hazard,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC_out,
  output logic [INSTR_WIDTH-1:0]       instr_out,
  output logic                         wb_ff_out,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
);

  // Beat layout at this instance's widths.
  typedef struct packed {
    logic [INSTMEM_LOG2_DEEP-1:0] pc;
    logic [INSTR_WIDTH-1:0]       instr;
    logic                         wb_ff;
  } payload_t;

  // Package reset payload resized to this instance.
  localparam payload_t PAYLOAD_RST = '{
    pc:    INSTMEM_LOG2_DEEP'(IFID_PAYLOAD_RST.pc),
    instr: INSTR_WIDTH'(IFID_PAYLOAD_RST.instr),
    wb_ff: IFID_PAYLOAD_RST.wb_ff
  };

  ifid_state_e state_r;
  ifid_state_e state_nxt_s;
  payload_t    main_r;
  payload_t    skid_r;
  payload_t    in_payload_s;
  logic        out_valid_r;
  logic        in_ready_r;
  logic        in_ready_s;
  logic        eff_ready_s;
  logic        accept_s;
  logic        emit_s;
  logic        stall_inc_s;
  logic        load_main_in_s;
  logic        load_main_skid_s;
  logic        load_skid_s;

  assign in_payload_s = '{pc: PC_in, instr: instr_in, wb_ff: wb_ff_in};

  // A decode hazard looks exactly like downstream not being ready.
  assign eff_ready_s = out_ready & ~hazard;

  // With the skid buffer, in_ready is a flop so it never depends on out_ready;
  // without it, a beat may enter only as the held one leaves.
  assign in_ready_s  = SKID_EN ? in_ready_r : (~out_valid_r | eff_ready_s);

  assign accept_s    = in_valid & in_ready_s;
  assign emit_s      = out_valid_r & eff_ready_s;
  assign stall_inc_s = out_valid_r & ~eff_ready_s;

  // Next occupancy and which payload register loads; flush overrides everything.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s    = ST_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            state_nxt_s    = ST_ONE;
            load_main_in_s = 1'b1;
          end else if (accept_s) begin
            // Only reachable with the skid buffer: park the new beat behind main.
            if (SKID_EN) begin
              state_nxt_s = ST_FULL;
              load_skid_s = 1'b1;
            end else begin
              state_nxt_s = ST_ONE;
            end
          end else if (emit_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (emit_s) begin
            state_nxt_s      = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register plus the registered handshake flags derived from it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_FULL);
    end
  end

  // Main register: drives the outputs directly; holds bit-exact unless loaded.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      main_r <= PAYLOAD_RST;
    end else if (load_main_in_s) begin
      main_r <= in_payload_s;
    end else if (load_main_skid_s) begin
      main_r <= skid_r;
    end else begin
      main_r <= main_r;
    end
  end

  // Skid register: catches the one beat that arrives after the stage stalls.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      skid_r <= PAYLOAD_RST;
    end else if (load_skid_s) begin
      skid_r <= in_payload_s;
    end else begin
      skid_r <= skid_r;
    end
  end

  ifid_stall_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_counter (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign PC_out    = main_r.pc;
  assign instr_out = main_r.instr;
  assign wb_ff_out = main_r.wb_ff;

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Directed bench for ifid_pipe_stage: default skid instance, a 4-bit stall
// counter instance and a SKID_EN=0 instance, each with a scoreboard or
// directed checks. Inputs change 1 time unit after posedge, sampled at negedge.
module tb_ifid_pipe_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        flush;
  logic [7:0]  PC_in;
  logic [31:0] instr_in;
  logic        wb_ff_in;

  logic        in_valid, hazard, out_ready;
  logic        in_ready, out_valid, wb_ff_out;
  logic [7:0]  PC_out;
  logic [31:0] instr_out;
  logic [15:0] stall_cnt;

  logic        s_in_valid, s_hazard, s_out_ready;
  logic        s_in_ready, s_out_valid, s_wb_out;
  logic [7:0]  s_pc_out;
  logic [31:0] s_instr_out;
  logic [3:0]  s_stall;

  logic        n_in_valid, n_hazard, n_out_ready;
  logic        n_in_ready, n_out_valid, n_wb_out;
  logic [7:0]  n_pc_out;
  logic [31:0] n_instr_out;
  logic [15:0] n_stall;

  int checks = 0;
  int errors = 0;

  logic [40:0] q_a[$];
  logic [40:0] q_n[$];

  ifid_pipe_stage dut (
    .CLK(CLK), .RST_N(RST_N), .PC_in(PC_in), .instr_in(instr_in), .wb_ff_in(wb_ff_in),
    .in_valid(in_valid), .in_ready(in_ready), .hazard(hazard), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .PC_out(PC_out), .instr_out(instr_out),
    .wb_ff_out(wb_ff_out), .stall_cnt(stall_cnt)
  );

  ifid_pipe_stage #(.STALL_CNT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .PC_in(PC_in), .instr_in(instr_in), .wb_ff_in(wb_ff_in),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .hazard(s_hazard), .flush(flush),
    .out_ready(s_out_ready), .out_valid(s_out_valid), .PC_out(s_pc_out), .instr_out(s_instr_out),
    .wb_ff_out(s_wb_out), .stall_cnt(s_stall)
  );

  ifid_pipe_stage #(.SKID_EN(1'b0)) dut_ns (
    .CLK(CLK), .RST_N(RST_N), .PC_in(PC_in), .instr_in(instr_in), .wb_ff_in(wb_ff_in),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .hazard(n_hazard), .flush(flush),
    .out_ready(n_out_ready), .out_valid(n_out_valid), .PC_out(n_pc_out), .instr_out(n_instr_out),
    .wb_ff_out(n_wb_out), .stall_cnt(n_stall)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk_instr(input logic [7:0] pc);
    return {pc, ~pc, 8'h3C, pc ^ 8'h5A};
  endfunction

  function automatic logic mk_wb(input logic [7:0] pc);
    return pc[0] ^ pc[3];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_payload(input logic [7:0] pc);
    PC_in    = pc;
    instr_in = mk_instr(pc);
    wb_ff_in = mk_wb(pc);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one beat to the SKID_EN=0 instance and hold it until accepted.
  task automatic ns_send(input logic [7:0] pc);
    bit ok;
    ok = 1'b0;
    step();
    n_in_valid = 1'b1;
    set_payload(pc);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (n_in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("ns_accept_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard for the default instance: push on accept, pop/compare on emit.
  always @(negedge CLK) begin
    if (!RST_N || flush) begin
      q_a.delete();
    end else begin
      if (out_valid && out_ready && !hazard) begin
        check("a_sb_underflow", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) begin
          logic [40:0] e;
          e = q_a.pop_front();
          check("a_sb_pc", 64'(PC_out), 64'(e[40:33]));
          check("a_sb_instr", 64'(instr_out), 64'(e[32:1]));
          check("a_sb_wb", 64'(wb_ff_out), 64'(e[0]));
        end
      end
      if (in_valid && in_ready) q_a.push_back({PC_in, instr_in, wb_ff_in});
    end
  end

  // Scoreboard for the SKID_EN=0 instance.
  always @(negedge CLK) begin
    if (!RST_N || flush) begin
      q_n.delete();
    end else begin
      if (n_out_valid && n_out_ready && !n_hazard) begin
        check("n_sb_underflow", 64'(q_n.size() != 0), 64'd1);
        if (q_n.size() != 0) begin
          logic [40:0] e;
          e = q_n.pop_front();
          check("n_sb_pc", 64'(n_pc_out), 64'(e[40:33]));
          check("n_sb_instr", 64'(n_instr_out), 64'(e[32:1]));
          check("n_sb_wb", 64'(n_wb_out), 64'(e[0]));
        end
      end
      if (n_in_valid && n_in_ready) q_n.push_back({PC_in, instr_in, wb_ff_in});
    end
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; flush = 1'b0;
    in_valid = 1'b1; hazard = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_hazard = 1'b0; s_out_ready = 1'b1;
    n_in_valid = 1'b0; n_hazard = 1'b0; n_out_ready = 1'b1;
    set_payload(8'h55);

    // Reset with a beat offered.
    step(); step();
    @(negedge CLK);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_pc", 64'(PC_out), 64'd0);
    check("rst_instr", 64'(instr_out), 64'd0);
    check("rst_wb", 64'(wb_ff_out), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_ns_valid", 64'(n_out_valid), 64'd0);
    step();
    RST_N = 1'b1; in_valid = 1'b0;

    // Streaming 0x00..0x0F, each beat out one cycle after its accept.
    for (int i = 0; i < 16; i++) begin
      step();
      in_valid = 1'b1;
      set_payload(8'(i));
      @(negedge CLK);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_pc", 64'(PC_out), 64'(i - 1));
      end
    end
    step(); in_valid = 1'b0;
    @(negedge CLK);
    check("stream_last_pc", 64'(PC_out), 64'h0F);
    step();
    @(negedge CLK);
    check("stream_drained", 64'(out_valid), 64'd0);

    // Back-pressure: 0x10 in main, 0x11 in skid, hazard five cycles.
    step(); in_valid = 1'b1; set_payload(8'h10);
    step(); set_payload(8'h11); hazard = 1'b1;
    @(negedge CLK);
    check("bp_in_ready_one", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      step(); set_payload(8'h12);
      @(negedge CLK);
      check("bp_in_ready_full", 64'(in_ready), 64'd0);
      check("bp_hold_pc", 64'(PC_out), 64'h10);
    end
    step(); hazard = 1'b0;
    @(negedge CLK);
    check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
    check("bp_pc_release", 64'(PC_out), 64'h10);
    check("bp_in_ready_rel", 64'(in_ready), 64'd0);
    step();
    @(negedge CLK);
    check("bp_pc_11", 64'(PC_out), 64'h11);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    @(negedge CLK);
    check("bp_pc_12", 64'(PC_out), 64'h12);
    step();
    @(negedge CLK);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with 0x20/0x21 and 0x22 offered.
    step(); in_valid = 1'b1; set_payload(8'h20); hazard = 1'b1;
    step(); set_payload(8'h21);
    step(); set_payload(8'h22); flush = 1'b1;
    @(negedge CLK);
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    step(); flush = 1'b0; in_valid = 1'b0; hazard = 1'b0;
    @(negedge CLK);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_stall_cnt", 64'(stall_cnt), 64'd7);
    for (int c = 0; c < 2; c++) begin
      step();
      @(negedge CLK);
      check("fl_no_emit", 64'(out_valid), 64'd0);
    end

    // Flush discards a beat accepted in the same cycle.
    step(); in_valid = 1'b1; set_payload(8'h30);
    step(); set_payload(8'h31); flush = 1'b1; hazard = 1'b1;
    @(negedge CLK);
    check("fl2_pc", 64'(PC_out), 64'h30);
    step(); flush = 1'b0; hazard = 1'b0; set_payload(8'h40);
    @(negedge CLK);
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    step(); in_valid = 1'b0;
    @(negedge CLK);
    check("fl2_next_pc", 64'(PC_out), 64'h40);
    check("fl2_next_valid", 64'(out_valid), 64'd1);
    step();

    // Reset mid-transfer together with flush.
    step(); in_valid = 1'b1; set_payload(8'h50); hazard = 1'b1;
    step(); set_payload(8'h51);
    step(); set_payload(8'h52); RST_N = 1'b0; flush = 1'b1;
    @(negedge CLK);
    check("rst2_before", 64'(out_valid), 64'd1);
    step(); RST_N = 1'b1; flush = 1'b0; in_valid = 1'b0; hazard = 1'b0;
    @(negedge CLK);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_pc", 64'(PC_out), 64'd0);
    check("rst2_instr", 64'(instr_out), 64'd0);
    check("rst2_stall", 64'(stall_cnt), 64'd0);

    // SKID_EN=0: streaming, 3-cycle hazard, combinational in_ready.
    for (int i = 0; i < 8; i++) ns_send(8'(8'h60 + i));
    for (int h = 0; h < 3; h++) begin
      step(); n_in_valid = 1'b1; set_payload(8'h68); n_hazard = 1'b1;
      @(negedge CLK);
      check("ns_hz_in_ready", 64'(n_in_ready), 64'd0);
      check("ns_hz_pc", 64'(n_pc_out), 64'h67);
    end
    step(); n_hazard = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    #1;
    check("ns_comb_low", 64'(n_in_ready), 64'd0);
    n_out_ready = 1'b1;
    #1;
    check("ns_comb_high", 64'(n_in_ready), 64'd1);
    for (int i = 8; i < 16; i++) ns_send(8'(8'h60 + i));
    step(); n_in_valid = 1'b0;
    step(); step();
    @(negedge CLK);
    check("ns_stall_cnt", 64'(n_stall), 64'd3);
    check("ns_drained", 64'(n_out_valid), 64'd0);

    // Saturation on the 4-bit counter instance.
    step(); s_in_valid = 1'b1; s_hazard = 1'b1; set_payload(8'h77);
    for (int k = 1; k <= 20; k++) begin
      step(); s_in_valid = 1'b0;
      @(negedge CLK);
      check("sat_cnt", 64'(s_stall), (k - 1 > 15) ? 64'd15 : 64'(k - 1));
    end
    check("sat_hold_pc", 64'(s_pc_out), 64'h77);
    step(); s_hazard = 1'b0;
    step(); step();

    check("sb_a_empty", 64'(q_a.size()), 64'd0);
    check("sb_n_empty", 64'(q_n.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
